// File: rtl/gru_fp_sequencer.sv
// gru_fp_sequencer: GRU forward-pass controller.
// Loads gate weights from ROM, sequences timesteps, guards every wait.
module gru_fp_sequencer #(
  parameter int INPUTDIMEN = 4,
  parameter int CELLNUM    = 4,
  parameter int DATABIT    = 16,
  parameter int WDEPTH     = 16,
  parameter int TIMEOUT    = 1023,
  localparam int BW = INPUTDIMEN*CELLNUM*DATABIT,
  localparam int XW = INPUTDIMEN*DATABIT,
  localparam int AW = $clog2(WDEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              reload,
  input  logic              abort,
  input  logic [7:0]        num_steps,
  output logic [AW-1:0]     w_addr,
  input  logic [6*DATABIT-1:0] w_q,
  output logic [BW-1:0]     wxr,
  output logic [BW-1:0]     wxz,
  output logic [BW-1:0]     wxh,
  output logic [BW-1:0]     whr,
  output logic [BW-1:0]     whz,
  output logic [BW-1:0]     whh,
  output logic              xt_req,
  input  logic              xt_valid,
  input  logic [XW-1:0]     xt_in,
  output logic [XW-1:0]     xt_out,
  output logic              hl_start,
  input  logic              hl_done,
  output logic              ave_start,
  output logic [7:0]        ave_t,
  output logic              head_start,
  input  logic              head_done,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              weights_valid
);
  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_FETCH, S_RUN, S_WAIT_HL,
    S_AVG, S_HEAD, S_WAIT_HEAD, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW:0]     r_lcnt;
  logic [TW-1:0]   r_wd;
  logic [7:0]      r_idx;
  logic [7:0]      r_steps;
  logic            r_err;
  logic            r_wvalid;
  logic [XW-1:0]   r_xt;
  logic [BW-1:0]   r_wxr, r_wxz, r_wxh;
  logic [BW-1:0]   r_whr, r_whz, r_whh;
  logic            w_tmo;
  logic            w_hit;
  logic            w_last;
  logic            w_cap;
  logic            w_wait;
  logic            w_accept;

  assign w_hit    = (r_wd == TW'(TIMEOUT-1));
  assign w_last   = (r_lcnt == (AW+1)'(WDEPTH));
  assign w_cap    = (r_state == S_LOAD) && !abort
                    && (r_lcnt != '0);
  assign w_wait   = (r_state == S_FETCH)
                    || (r_state == S_WAIT_HL)
                    || (r_state == S_WAIT_HEAD);
  assign w_accept = (r_state == S_IDLE) && start && !abort;

  always_comb begin
    w_next = r_state;
    w_tmo  = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (w_accept && num_steps != '0)
          w_next = (reload || !r_wvalid) ? S_LOAD : S_FETCH;
      S_LOAD:
        if (w_last) w_next = S_FETCH;
      S_FETCH:
        if (xt_valid) w_next = S_RUN;
        else if (w_hit) begin
          w_next = S_IDLE;
          w_tmo  = 1'b1;
        end
      S_RUN:
        w_next = S_WAIT_HL;
      S_WAIT_HL:
        if (hl_done) w_next = S_AVG;
        else if (w_hit) begin
          w_next = S_IDLE;
          w_tmo  = 1'b1;
        end
      S_AVG:
        w_next = (r_idx == r_steps) ? S_HEAD : S_FETCH;
      S_HEAD:
        w_next = S_WAIT_HEAD;
      S_WAIT_HEAD:
        if (head_done) w_next = S_DONE;
        else if (w_hit) begin
          w_next = S_IDLE;
          w_tmo  = 1'b1;
        end
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
    if (abort) begin
      w_next = S_IDLE;
      w_tmo  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_lcnt   <= '0;
      r_wd     <= '0;
      r_idx    <= '0;
      r_steps  <= '0;
      r_err    <= 1'b0;
      r_wvalid <= 1'b0;
      r_xt     <= '0;
      r_wxr    <= '0;
      r_wxz    <= '0;
      r_wxh    <= '0;
      r_whr    <= '0;
      r_whz    <= '0;
      r_whh    <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_wd <= '0;
      else if (w_wait)       r_wd <= r_wd + 1'b1;
      if (r_state == S_LOAD && w_next == S_LOAD)
        r_lcnt <= r_lcnt + 1'b1;
      else
        r_lcnt <= '0;
      // Entry k arrives one cycle after its address; 16 shifts put entry 0 on top.
      if (w_cap) begin
        r_whh <= {r_whh[BW-DATABIT-1:0], w_q[0*DATABIT +: DATABIT]};
        r_whz <= {r_whz[BW-DATABIT-1:0], w_q[1*DATABIT +: DATABIT]};
        r_whr <= {r_whr[BW-DATABIT-1:0], w_q[2*DATABIT +: DATABIT]};
        r_wxh <= {r_wxh[BW-DATABIT-1:0], w_q[3*DATABIT +: DATABIT]};
        r_wxz <= {r_wxz[BW-DATABIT-1:0], w_q[4*DATABIT +: DATABIT]};
        r_wxr <= {r_wxr[BW-DATABIT-1:0], w_q[5*DATABIT +: DATABIT]};
      end
      if (r_state == S_IDLE && w_next == S_LOAD)
        r_wvalid <= 1'b0;
      else if (w_cap && w_last)
        r_wvalid <= 1'b1;
      if (w_accept) begin
        r_err   <= (num_steps == '0);
        r_steps <= num_steps;
        r_idx   <= '0;
      end else if (w_tmo) begin
        r_err <= 1'b1;
      end
      if (r_state == S_RUN && !abort)
        r_idx <= r_idx + 1'b1;
      if (r_state == S_FETCH && xt_valid && !abort)
        r_xt <= xt_in;
    end
  end

  assign w_addr = (r_state == S_LOAD && !r_lcnt[AW])
                  ? r_lcnt[AW-1:0] : '0;
  assign wxr           = r_wxr;
  assign wxz           = r_wxz;
  assign wxh           = r_wxh;
  assign whr           = r_whr;
  assign whz           = r_whz;
  assign whh           = r_whh;
  assign xt_req        = (r_state == S_FETCH);
  assign xt_out        = r_xt;
  assign hl_start      = (r_state == S_RUN) && !abort;
  assign ave_start     = (r_state == S_AVG) && !abort;
  assign ave_t         = r_idx;
  assign head_start    = (r_state == S_HEAD) && !abort;
  assign done          = (r_state == S_DONE) && !abort;
  assign busy          = (r_state != S_IDLE);
  assign error         = r_err;
  assign weights_valid = r_wvalid;
endmodule

// File: tb/tb_gru_fp_sequencer.sv
// tb_gru_fp_sequencer: randomized bench for gru_fp_sequencer
// against a cycle-count and weight-placement model.
module tb_gru_fp_sequencer;
  localparam int TIMEOUT = 1023;
  localparam int WDEPTH  = 16;

  logic         clk, rst_n, start, reload, abort;
  logic [7:0]   num_steps;
  logic [3:0]   w_addr;
  logic [95:0]  w_q;
  logic [255:0] wxr, wxz, wxh, whr, whz, whh;
  logic         xt_req, xt_valid;
  logic [63:0]  xt_in, xt_out;
  logic         hl_start, hl_done, ave_start;
  logic [7:0]   ave_t;
  logic         head_start, head_done;
  logic         busy, done, error, weights_valid;

  int checks = 0;
  int errors = 0;
  logic [95:0] rom [16];
  bit wv_m;

  int o_end_i, o_done_i, o_err_i, o_hl_i, o_head_i, o_fx_i;
  int o_n_hl, o_n_head, o_n_done, o_xreq, o_bad_pulse;
  int o_err_at1, o_addr_nz;
  logic [3:0]  o_addr[$];
  logic        o_wv[$];
  logic [7:0]  o_avet[$];
  logic [63:0] o_xt[$], exp_xt[$];

  gru_fp_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .reload(reload), .abort(abort),
    .num_steps(num_steps), .w_addr(w_addr), .w_q(w_q),
    .wxr(wxr), .wxz(wxz), .wxh(wxh),
    .whr(whr), .whz(whz), .whh(whh),
    .xt_req(xt_req), .xt_valid(xt_valid),
    .xt_in(xt_in), .xt_out(xt_out),
    .hl_start(hl_start), .hl_done(hl_done),
    .ave_start(ave_start), .ave_t(ave_t),
    .head_start(head_start), .head_done(head_done),
    .busy(busy), .done(done), .error(error),
    .weights_valid(weights_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) w_q <= rom[w_addr];

  // Bank f field of entry k lands in slice k counted from the top.
  function automatic logic [255:0] exp_bank(int f);
    logic [255:0] b;
    b = '0;
    for (int k = 0; k < 16; k++)
      b[255-16*k -: 16] = rom[k][16*f +: 16];
    return b;
  endfunction

  function automatic logic [255:0] dut_bank(int f);
    case (f)
      0: return whh;
      1: return whz;
      2: return whr;
      3: return wxh;
      4: return wxz;
      default: return wxr;
    endcase
  endfunction

  // Per step: fetch (xd+1), run 1, wait hd, avg 1; then head, wait, done.
  function automatic int exp_done(bit ld, int ns, int xd,
                                  int hd, int hdd);
    return (ld ? WDEPTH + 1 : 0) + ns * (xd + hd + 3) + hdd + 2;
  endfunction

  task automatic run_seq(input bit rl, input int ns, input int xd,
                         input int hd, input int hdd,
                         input int ab_at, input bit spur,
                         input int budget);
    int fcnt, hcd, dcd;
    fcnt = 0; hcd = 0; dcd = 0;
    o_end_i = -1; o_done_i = -1; o_err_i = -1;
    o_hl_i = -1; o_head_i = -1; o_fx_i = -1;
    o_n_hl = 0; o_n_head = 0; o_n_done = 0; o_xreq = 0;
    o_bad_pulse = 0; o_err_at1 = -1; o_addr_nz = 0;
    o_addr.delete(); o_wv.delete(); o_avet.delete();
    o_xt.delete(); exp_xt.delete();
    @(negedge clk);
    start = 1'b1; reload = rl; num_steps = 8'(ns);
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      o_addr.push_back(w_addr);
      o_wv.push_back(weights_valid);
      if (w_addr != 4'd0) o_addr_nz++;
      if (i == 1) o_err_at1 = int'(error);
      if (error === 1'b1 && o_err_i < 0) o_err_i = i;
      if (xt_req) begin
        o_xreq++;
        if (o_fx_i < 0) o_fx_i = i;
      end
      if (hl_start) begin
        o_n_hl++; o_hl_i = i;
        o_xt.push_back(xt_out);
      end
      if (ave_start) o_avet.push_back(ave_t);
      if (head_start) begin o_n_head++; o_head_i = i; end
      if (done) begin o_n_done++; o_done_i = i; end
      if (!busy) begin o_end_i = i; break; end
      xt_valid = 1'b0;
      if (xt_req) begin
        if (fcnt == xd) begin
          xt_valid = 1'b1;
          xt_in = {$urandom, $urandom};
          exp_xt.push_back(xt_in);
        end
        fcnt++;
      end else fcnt = 0;
      hl_done = 1'b0;
      if (hl_start) hcd = hd;
      else if (hcd > 0) begin hcd--; hl_done = (hcd == 0); end
      head_done = 1'b0;
      if (head_start) dcd = hdd;
      else if (dcd > 0) begin dcd--; head_done = (dcd == 0); end
      if (spur && xt_req) begin hl_done = 1'b1; head_done = 1'b1; end
      if (i == ab_at) begin
        abort = 1'b1;
        #1;
        if (hl_start | ave_start | head_start | done) o_bad_pulse++;
      end
    end
    start = 1'b0; abort = 1'b0; xt_valid = 1'b0;
    hl_done = 1'b0; head_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; reload = 1'b0; abort = 1'b0;
    num_steps = '0; xt_valid = 1'b0; xt_in = '0;
    hl_done = 1'b0; head_done = 1'b0;
    for (int k = 0; k < 16; k++) rom[k] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, weights_valid, xt_req, hl_start,
         ave_start, head_start} !== 8'h00) begin
      errors++;
      $display("FAIL rst_flags: got %b exp 0",
        {busy, done, error, weights_valid, xt_req, hl_start,
         ave_start, head_start});
    end
    checks++;
    if (w_addr !== 4'd0 || ave_t !== 8'd0) begin
      errors++;
      $display("FAIL rst_cnt: addr %0h t %0h exp 0", w_addr, ave_t);
    end
    checks++;
    if ((|{wxr, wxz, wxh, whr, whz, whh, xt_out}) !== 1'b0) begin
      errors++;
      $display("FAIL rst_banks: got nonzero exp 0");
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: busy %b exp 0", busy);
    end
    wv_m = 1'b0;
  endtask

  task automatic test_load_run();
    int bad;
    for (int k = 0; k < 16; k++) rom[k] = {6{16'(k)}};
    run_seq(1'b1, 3, 0, 5, 4, -1, 1'b0, 300);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (o_addr.size() <= i || o_addr[i] !== 4'(i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL lr_addr: %0d bad steps exp 0", bad);
    end
    checks++;
    if (o_wv.size() < 18 || o_wv[16] !== 1'b0 || o_wv[17] !== 1'b1)
    begin
      errors++;
      $display("FAIL lr_wv: rise not at cycle 17->18");
    end
    checks++;
    if (whh !== 256'h0000000100020003000400050006000700080009000a000b000c000d000e000f)
    begin
      errors++;
      $display("FAIL lr_whh: got %h", whh);
    end
    for (int f = 0; f < 6; f++) begin
      checks++;
      if (dut_bank(f) !== exp_bank(f)) begin
        errors++;
        $display("FAIL lr_bank%0d: got %h exp %h",
          f, dut_bank(f), exp_bank(f));
      end
    end
    checks++;
    if (o_done_i != exp_done(1'b1, 3, 0, 5, 4)) begin
      errors++;
      $display("FAIL lr_done: got %0d exp %0d",
        o_done_i, exp_done(1'b1, 3, 0, 5, 4));
    end
    checks++;
    if (o_end_i != o_done_i + 1 || o_n_done != 1) begin
      errors++;
      $display("FAIL lr_end: end %0d done %0d n %0d",
        o_end_i, o_done_i, o_n_done);
    end
    checks++;
    if (o_n_hl != 3 || exp_xt.size() != 3 || o_n_head != 1) begin
      errors++;
      $display("FAIL lr_cnt: hl %0d xt %0d head %0d exp 3 3 1",
        o_n_hl, exp_xt.size(), o_n_head);
    end
    bad = 0;
    for (int j = 0; j < 3; j++) begin
      if (o_avet.size() <= j || o_avet[j] !== 8'(j + 1)) bad++;
      if (o_xt.size() <= j || exp_xt.size() <= j
          || o_xt[j] !== exp_xt[j]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL lr_seq: %0d ave_t/xt mismatches exp 0", bad);
    end
    wv_m = 1'b1;
  endtask

  task automatic test_no_reload();
    run_seq(1'b0, 2, 0, 2, 2, -1, 1'b1, 200);
    checks++;
    if (o_fx_i != 1 || o_addr_nz != 0) begin
      errors++;
      $display("FAIL nr_fetch: first %0d addr_nz %0d exp 1 0",
        o_fx_i, o_addr_nz);
    end
    checks++;
    if (o_done_i != exp_done(1'b0, 2, 0, 2, 2)) begin
      errors++;
      $display("FAIL nr_done: got %0d exp %0d",
        o_done_i, exp_done(1'b0, 2, 0, 2, 2));
    end
    checks++;
    if (o_avet.size() != 2 || o_avet[1] !== 8'd2) begin
      errors++;
      $display("FAIL nr_avet: size %0d exp 2", o_avet.size());
    end
    checks++;
    if (whh !== exp_bank(0) || weights_valid !== 1'b1) begin
      errors++;
      $display("FAIL nr_keep: wv %b whh %h", weights_valid, whh);
    end
  endtask

  task automatic test_zero_steps();
    run_seq(1'b1, 0, 0, 1, 1, -1, 1'b0, 20);
    checks++;
    if (o_end_i != 1 || o_err_at1 != 1 || o_n_hl != 0) begin
      errors++;
      $display("FAIL zs_err: end %0d err %0d hl %0d exp 1 1 0",
        o_end_i, o_err_at1, o_n_hl);
    end
    checks++;
    if (o_wv.size() < 1 || o_wv[0] !== 1'b1) begin
      errors++;
      $display("FAIL zs_wv: weights dropped");
    end
    run_seq(1'b0, 1, 0, 1, 1, -1, 1'b0, 50);
    checks++;
    if (o_err_at1 != 0 || o_done_i != exp_done(1'b0, 1, 0, 1, 1))
    begin
      errors++;
      $display("FAIL zs_clear: err %0d done %0d exp 0 %0d",
        o_err_at1, o_done_i, exp_done(1'b0, 1, 0, 1, 1));
    end
  endtask

  task automatic test_timeout();
    run_seq(1'b0, 2, 0, 0, 1, -1, 1'b0, 1200);
    checks++;
    if (o_err_i - o_hl_i != TIMEOUT + 1 || o_end_i != o_err_i) begin
      errors++;
      $display("FAIL to_hl: err %0d hl %0d end %0d exp gap %0d",
        o_err_i, o_hl_i, o_end_i, TIMEOUT + 1);
    end
    checks++;
    if (weights_valid !== 1'b1 || o_n_done != 0) begin
      errors++;
      $display("FAIL to_keep: wv %b done %0d exp 1 0",
        weights_valid, o_n_done);
    end
    run_seq(1'b0, 1, 0, 2, 0, -1, 1'b0, 1200);
    checks++;
    if (o_err_i - o_head_i != TIMEOUT + 1 || o_end_i != o_err_i) begin
      errors++;
      $display("FAIL to_head: err %0d head %0d exp gap %0d",
        o_err_i, o_head_i, TIMEOUT + 1);
    end
    run_seq(1'b0, 1, 5000, 1, 1, -1, 1'b0, 1200);
    checks++;
    if (o_err_i - o_fx_i != TIMEOUT || o_end_i != o_err_i) begin
      errors++;
      $display("FAIL to_fetch: err %0d fetch %0d exp gap %0d",
        o_err_i, o_fx_i, TIMEOUT);
    end
  endtask

  task automatic test_abort_load();
    run_seq(1'b1, 3, 0, 2, 2, 9, 1'b0, 100);
    checks++;
    if (o_end_i != 10 || o_addr.size() < 10 || o_addr[8] !== 4'd8)
    begin
      errors++;
      $display("FAIL ab_load: end %0d exp 10", o_end_i);
    end
    checks++;
    if (o_wv.size() < 10 || o_wv[9] !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL ab_wv: wv/error not 0 after abort");
    end
    wv_m = 1'b0;
  endtask

  task automatic test_fetch_delay();
    run_seq(1'b0, 1, 10, 2, 2, -1, 1'b0, 200);
    checks++;
    if (o_fx_i != WDEPTH + 2 || o_xreq != 11) begin
      errors++;
      $display("FAIL fd_req: first %0d cycles %0d exp %0d 11",
        o_fx_i, o_xreq, WDEPTH + 2);
    end
    checks++;
    if (exp_xt.size() != 1 || o_xt.size() != 1
        || o_xt[0] !== exp_xt[0]) begin
      errors++;
      $display("FAIL fd_latch: sent %0d seen %0d",
        exp_xt.size(), o_xt.size());
    end
    checks++;
    if (o_done_i != exp_done(1'b1, 1, 10, 2, 2)
        || whr !== exp_bank(2)) begin
      errors++;
      $display("FAIL fd_done: got %0d exp %0d",
        o_done_i, exp_done(1'b1, 1, 10, 2, 2));
    end
    wv_m = 1'b1;
  endtask

  task automatic test_abort_run();
    run_seq(1'b0, 2, 0, 2, 2, 2, 1'b0, 100);
    checks++;
    if (o_end_i != 3 || o_bad_pulse != 0 || o_n_done != 0) begin
      errors++;
      $display("FAIL ar: end %0d pulses %0d done %0d exp 3 0 0",
        o_end_i, o_bad_pulse, o_n_done);
    end
  endtask

  task automatic test_random();
    bit rl, sp, ld;
    int ns, xd, hd, hdd, bad;
    for (int k = 0; k < 16; k++)
      rom[k] = {$urandom, $urandom, $urandom};
    for (int r = 0; r < 6; r++) begin
      rl  = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ns  = $urandom_range(1, 5);
      xd  = $urandom_range(0, 3);
      hd  = $urandom_range(1, 6);
      hdd = $urandom_range(1, 6);
      sp  = 1'($urandom_range(0, 1));
      ld  = rl || !wv_m;
      run_seq(rl, ns, xd, hd, hdd, -1, sp, 400);
      checks++;
      if (o_done_i != exp_done(ld, ns, xd, hd, hdd)
          || o_end_i != o_done_i + 1) begin
        errors++;
        $display("FAIL rnd%0d_done: got %0d exp %0d",
          r, o_done_i, exp_done(ld, ns, xd, hd, hdd));
      end
      bad = 0;
      for (int j = 0; j < ns; j++) begin
        if (o_avet.size() <= j || o_avet[j] !== 8'(j + 1)) bad++;
        if (o_xt.size() <= j || exp_xt.size() <= j
            || o_xt[j] !== exp_xt[j]) bad++;
      end
      checks++;
      if (bad != 0 || o_n_hl != ns || o_n_head != 1) begin
        errors++;
        $display("FAIL rnd%0d_seq: bad %0d hl %0d exp 0 %0d",
          r, bad, o_n_hl, ns);
      end
      checks++;
      if (wxr !== exp_bank(5) || whz !== exp_bank(1)
          || error !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_bank: wxr %h exp %h",
          r, wxr, exp_bank(5));
      end
      wv_m = 1'b1;
    end
  endtask

  task automatic test_long();
    run_seq(1'b0, 255, 0, 1, 1, -1, 1'b0, 1200);
    checks++;
    if (o_avet.size() != 255 || o_avet[254] !== 8'd255) begin
      errors++;
      $display("FAIL long_t: size %0d exp 255", o_avet.size());
    end
    checks++;
    if (o_done_i != exp_done(1'b0, 255, 0, 1, 1)) begin
      errors++;
      $display("FAIL long_done: got %0d exp %0d",
        o_done_i, exp_done(1'b0, 255, 0, 1, 1));
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1'b1; reload = 1'b1; num_steps = 8'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || weights_valid !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre: busy %b wv %b exp 1 1",
        busy, weights_valid);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, weights_valid, xt_req, error} !== 4'b0
        || (|{whh, wxr}) !== 1'b0) begin
      errors++;
      $display("FAIL ar_clr: busy %b wv %b exp 0 0",
        busy, weights_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_no_reload();
    test_zero_steps();
    test_timeout();
    test_abort_load();
    test_fetch_delay();
    test_abort_run();
    test_random();
    test_long();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end
endmodule
